div_reconstruct_checker: RTL and testbench

Sequential back-end checker for the 16/8 array dividers. It takes a dividend/divisor pair and the quotient/remainder a divider produced, and rebuilds the dividend as q·d + r with an 8-step shift-add multiplier. It reports the absolute reconstruction error per sample and keeps running error statistics for MAE evaluation. It sits downstream of any divider under test in the characterisation harness, behind a valid/ready handshake.

---
 rtl/div_reconstruct_checker_pkg.sv | 21 ++
 rtl/div_reconstruct_checker_if.sv | 31 +++
 rtl/div_reconstruct_checker_shift_add_mul8.sv | 38 +++
 rtl/div_reconstruct_checker.sv | 150 +++++++++++++++
 tb/tb_div_reconstruct_checker.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/div_reconstruct_checker_pkg.sv
// Shared widths, saturation limits and FSM encoding for the divider reconstruction checker.
package div_recon_pkg;

    localparam int N_W    = 16;
    localparam int D_W    = 8;
    localparam int REC_W  = 17;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 16;
    localparam int STEP_W = 3;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_reconstruct_checker_if.sv
// Sample/result handshake bus plus statistics readout of the reconstruction checker.
interface div_reconstruct_checker_if;
    import div_recon_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [N_W-1:0]   n;
    logic [D_W-1:0]   d;
    logic [D_W-1:0]   q;
    logic [D_W-1:0]   r;
    logic             out_valid;
    logic             out_ready;
    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] err;
    logic             exact;
    logic             stat_clr;
    logic [ACC_W-1:0] acc_err;
    logic [CNT_W-1:0] sample_cnt;
    logic [REC_W-1:0] max_err;

    modport master (
        output in_valid, n, d, q, r, out_ready, stat_clr,
        input  in_ready, out_valid, rec, err, exact, acc_err, sample_cnt, max_err
    );

    modport slave (
        input  in_valid, n, d, q, r, out_ready, stat_clr,
        output in_ready, out_valid, rec, err, exact, acc_err, sample_cnt, max_err
    );

endinterface

// File: rtl/div_reconstruct_checker_shift_add_mul8.sv
// Eight-step LSB-first shift-add multiplier; product is exact once done has been seen.
module shift_add_mul8
    import div_recon_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [D_W-1:0] mcand,
    input  logic [D_W-1:0] mplier,
    output logic [N_W-1:0] product,
    output logic           done
);

    logic [STEP_W-1:0] step;
    logic              busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
            step    <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            product <= '0;
            step    <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            if (mplier[step])
                product <= product + (N_W'(mcand) << step);
            step <= step + STEP_W'(1);
            if (step == STEP_W'(D_W - 1))
                busy <= 1'b0;
        end
    end

    // High during the final iteration so the controller leaves MUL on the same edge.
    assign done = busy && (step == STEP_W'(D_W - 1));

endmodule

// File: rtl/div_reconstruct_checker.sv
// Rebuilds a divider's dividend as q*d + r, reports |n - rec| and keeps saturating error statistics.
module div_reconstruct_checker
    import div_recon_pkg::*;
(
    input logic                       clk,
    input logic                       rst,
    div_reconstruct_checker_if.slave  bus
);

    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                                  input logic [REC_W-1:0] add);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W - REC_W + 1){1'b0}}, add};
        return sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    endfunction

    function automatic logic [REC_W-1:0] abs_diff(input logic [REC_W-1:0] a,
                                                   input logic [REC_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             ready_c;
    logic             valid_c;

    logic [N_W-1:0]   n_r;
    logic [D_W-1:0]   d_r;
    logic [D_W-1:0]   q_r;
    logic [D_W-1:0]   r_r;

    logic [N_W-1:0]   product;
    logic             mul_done;

    logic [REC_W-1:0] rec_c;
    logic [REC_W-1:0] err_c;
    logic [REC_W-1:0] rec_o;
    logic [REC_W-1:0] err_o;
    logic             exact_o;

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [REC_W-1:0] max_r;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready_c   = 1'b0;
        valid_c   = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (mul_done)
                    state_nxt = ADD;
            end
            ADD: begin
                state_nxt = DONE;
            end
            DONE: begin
                valid_c = 1'b1;
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture stage: operands are frozen at the handshake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r <= '0;
            d_r <= '0;
            q_r <= '0;
            r_r <= '0;
        end else if (accept) begin
            n_r <= bus.n;
            d_r <= bus.d;
            q_r <= bus.q;
            r_r <= bus.r;
        end
    end

    shift_add_mul8 u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .mcand   (d_r),
        .mplier  (q_r),
        .product (product),
        .done    (mul_done)
    );

    // Add/compare stage: evaluated during ADD, registered on the edge into DONE.
    assign rec_c = {1'b0, product} + {{(REC_W - D_W){1'b0}}, r_r};
    assign err_c = abs_diff({1'b0, n_r}, rec_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_o   <= '0;
            err_o   <= '0;
            exact_o <= 1'b0;
        end else if (state == ADD) begin
            rec_o   <= rec_c;
            err_o   <= err_c;
            exact_o <= (err_c == '0);
        end
    end

    // A clear on the ADD edge drops that sample from the statistics.
    always_ff @(posedge clk) begin
        if (rst || bus.stat_clr) begin
            acc_r <= '0;
            cnt_r <= '0;
            max_r <= '0;
        end else if (state == ADD) begin
            acc_r <= sat_acc(acc_r, err_c);
            cnt_r <= sat_inc(cnt_r);
            if (err_c > max_r)
                max_r <= err_c;
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.out_valid  = valid_c;
    assign bus.rec        = rec_o;
    assign bus.err        = err_o;
    assign bus.exact      = exact_o;
    assign bus.acc_err    = acc_r;
    assign bus.sample_cnt = cnt_r;
    assign bus.max_err    = max_r;

endmodule

// File: tb/tb_div_reconstruct_checker.sv
// Scoreboard bench for div_reconstruct_checker: directed test-plan samples plus random traffic.
module tb_div_reconstruct_checker;
    import div_recon_pkg::*;

    typedef struct {
        logic [16:0] rec;
        logic [16:0] err;
        logic        exact;
        logic [31:0] acc;
        logic [15:0] cnt;
        logic [16:0] mx;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    longint acc_m;
    longint cnt_m;
    longint max_m;

    div_reconstruct_checker_if bus ();

    div_reconstruct_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    // Reference: plain arithmetic on the spec's definitions.
    task automatic send(input int nn, input int dd, input int qq, input int rr,
                        input int hold, input bit clr);
        int     w;
        int     j;
        longint rec_i;
        longint err_i;
        exp_t   e;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_wait", (w < 100), 1);
        if (w >= 100) return;
        bus.in_valid  = 1'b1;
        bus.n         = 16'(nn);
        bus.d         = 8'(dd);
        bus.q         = 8'(qq);
        bus.r         = 8'(rr);
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.n        = 16'($urandom);
        bus.d        = 8'($urandom);
        bus.q        = 8'($urandom);
        bus.r        = 8'($urandom);

        rec_i = longint'(qq) * longint'(dd) + longint'(rr);
        err_i = (nn >= rec_i) ? nn - rec_i : rec_i - nn;
        if (clr) begin
            acc_m = 0; cnt_m = 0; max_m = 0;
        end else begin
            acc_m = acc_m + err_i;
            if (acc_m > 64'hFFFF_FFFF) acc_m = 64'hFFFF_FFFF;
            if (cnt_m < 65535) cnt_m = cnt_m + 1;
            if (err_i > max_m) max_m = err_i;
        end
        e.rec   = 17'(rec_i);
        e.err   = 17'(err_i);
        e.exact = (err_i == 0);
        e.acc   = 32'(acc_m);
        e.cnt   = 16'(cnt_m);
        e.mx    = 17'(max_m);
        sb.push_back(e);

        j = 0;
        while (bus.out_valid !== 1'b1 && j < 40) begin
            chk("in_ready_busy", bus.in_ready, 0);
            @(posedge clk); #1;
            j++;
            if (clr && j == 8) bus.stat_clr = 1'b1;
            if (j == 9) bus.stat_clr = 1'b0;
        end
        bus.stat_clr = 1'b0;
        chk("latency", j, 9);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
        end
    endtask

    // Monitor: compare every DONE cycle against the head, pop on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("out_without_expect", sb.size(), 1);
                end else begin
                    chk("rec", bus.rec, sb[0].rec);
                    chk("err", bus.err, sb[0].err);
                    chk("exact", bus.exact, sb[0].exact);
                    chk("acc_err", bus.acc_err, sb[0].acc);
                    chk("sample_cnt", bus.sample_cnt, sb[0].cnt);
                    chk("max_err", bus.max_err, sb[0].mx);
                    chk("in_ready_done", bus.in_ready, 0);
                    if (bus.out_ready === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int nn, dd, qq, rr;
        total = 0; bad = 0;
        acc_m = 0; cnt_m = 0; max_m = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.n         = '0;
        bus.d         = '0;
        bus.q         = '0;
        bus.r         = '0;
        bus.out_ready = 1'b1;
        bus.stat_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_rec", bus.rec, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_exact", bus.exact, 0);
        chk("rst_acc", bus.acc_err, 0);
        chk("rst_cnt", bus.sample_cnt, 0);
        chk("rst_max", bus.max_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of MUL aborts the sample.
        bus.in_valid = 1'b1;
        bus.n = 16'd300; bus.d = 8'd9; bus.q = 8'd30; bus.r = 8'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_rec", bus.rec, 0);
        chk("abort_err", bus.err, 0);
        chk("abort_acc", bus.acc_err, 0);
        chk("abort_cnt", bus.sample_cnt, 0);
        chk("abort_max", bus.max_err, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_output", bus.out_valid, 0);

        send(100, 7, 14, 2, 0, 0);
        send(100, 7, 13, 2, 0, 0);
        send(90, 7, 13, 2, 0, 0);
        send(0, 255, 255, 255, 0, 0);
        send(65535, 0, 0, 0, 0, 0);
        send(1234, 10, 123, 4, 5, 0);
        send(500, 3, 166, 1, 0, 1);
        send(77, 0, 200, 77, 0, 0);

        for (int i = 0; i < 40; i++) begin
            nn = $urandom_range(0, 65535);
            dd = $urandom_range(0, 255);
            qq = $urandom_range(0, 255);
            rr = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1 && dd != 0) begin
                qq = nn / dd;
                if (qq > 255) qq = 255;
                rr = nn % dd;
            end
            send(nn, dd, qq, rr, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
